// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, vectors, id encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package irq_pkg;

  // Register offsets within the 3-byte window
  typedef enum logic [1:0] {
    STATUS = 2'd0,
    MASK   = 2'd1,
    ID     = 2'd2
  } reg_off_e;

  localparam logic [15:0] NMI_VEC = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC = 16'hFFFE;
  localparam logic [7:0]  ID_NONE = 8'h80;

  // Index of the lowest set bit, or ID_NONE when nothing is pending
  function automatic logic [7:0] lowest_id(input logic [7:0] v);
    logic [7:0] r;
    r = ID_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 8'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/interrupt_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a third flop for rising-edge detect.
// Latency: rise is high in the cycle after the 2nd capturing edge (registered by users on the 3rd).
// Backpressure: none; every synchronized 0->1 transition yields a single-cycle rise pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  // Synchronizer chain and edge-history flop; all cleared while in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/interrupt_ctrl.sv
// CPU-bus interrupt controller: latched maskable IRQs (status/mask/id window) plus one NMI latch.
// Latency: source edge lands in status on the 3rd clk edge; irq follows status&mask one edge later.
// Backpressure: none; one register access per phi2 rising transition, no stalls.
module interrupt_ctrl
  import irq_pkg::*;
#(
  parameter int          NSRC = 4,
  parameter logic [15:0] BASE = 16'h4000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            src_nmi,
  input  logic [15:0]     addr,
  input  logic [7:0]      wdata,
  input  logic            rw,
  input  logic            phi2,
  output logic [7:0]      rdata,
  output logic            sel,
  output logic            irq,
  output logic            nmi
);

  // Bits above NSRC never hold state and always read back as zero
  localparam logic [7:0] VALID = 8'((9'd1 << NSRC) - 9'd1);

  logic [NSRC:0] src_all;
  logic [NSRC:0] rise;
  logic [7:0]    rise8;
  logic          phi2_q;
  logic          strobe;
  logic [15:0]   off;
  logic          wr_status;
  logic          wr_mask;
  logic          rd_nmi;
  logic [7:0]    status;
  logic [7:0]    mask;
  logic [7:0]    status_nxt;
  logic [7:0]    pend;
  logic [7:0]    id;
  logic          nmi_pend;

  assign src_all = {src_nmi, src_irq};

  // One synchronizer per IRQ source; the top slot carries the NMI request
  for (genvar g = 0; g <= NSRC; g++) begin : g_sync
    sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (src_all[g]),
      .rise  (rise[g])
    );
  end

  // Widen the IRQ edge pulses to the 8-bit register width
  always_comb begin
    rise8            = '0;
    rise8[NSRC-1:0]  = rise[NSRC-1:0];
  end

  // phi2 history: strobe fires once per bus cycle on the 0->1 transition
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phi2_q <= 1'b0;
    else        phi2_q <= phi2;
  end

  assign strobe    = phi2 & ~phi2_q;
  assign off       = addr - BASE;
  assign sel       = (off < 16'd3);
  assign wr_status = strobe & ~rw & sel & (off[1:0] == STATUS);
  assign wr_mask   = strobe & ~rw & sel & (off[1:0] == MASK);
  assign rd_nmi    = strobe & rw & (addr == NMI_VEC);

  assign pend = status & mask;
  assign id   = lowest_id(pend);

  // W1C clear first, then OR in new edges so a coincident edge survives the clear
  always_comb begin
    status_nxt = status;
    if (wr_status) status_nxt = status_nxt & ~wdata;
    status_nxt = (status_nxt | rise8) & VALID;
  end

  // Interrupt state: status, mask, NMI latch and the registered irq line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status   <= 8'h00;
      mask     <= 8'h00;
      nmi_pend <= 1'b0;
      irq      <= 1'b1;
    end else begin
      status   <= status_nxt;
      if (wr_mask) mask <= wdata & VALID;
      nmi_pend <= rise[NSRC] | (nmi_pend & ~rd_nmi);
      irq      <= ~|pend;
    end
  end

  assign nmi = ~nmi_pend;

  // Register read mux, zero outside the window
  always_comb begin
    rdata = 8'h00;
    if (sel) begin
      case (off[1:0])
        STATUS:  rdata = status;
        MASK:    rdata = mask;
        ID:      rdata = id;
        default: rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Self-checking bench: directed scenarios then randomized bus/source traffic against a reference model.
// Latency: model predicts state after each rising clk edge; outputs sampled 1ns after the edge.
// Backpressure: n/a.
module tb_interrupt_ctrl;

  localparam int          NSRC = 4;
  localparam logic [15:0] BASE = 16'h4000;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] src_irq;
  logic            src_nmi;
  logic [15:0]     addr;
  logic [7:0]      wdata;
  logic            rw;
  logic            phi2;
  logic [7:0]      rdata;
  logic            sel;
  logic            irq;
  logic            nmi;

  interrupt_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .src_irq (src_irq),
    .src_nmi (src_nmi),
    .addr    (addr),
    .wdata   (wdata),
    .rw      (rw),
    .phi2    (phi2),
    .rdata   (rdata),
    .sel     (sel),
    .irq     (irq),
    .nmi     (nmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural state plus the input values seen at past clock edges
  bit [7:0]    m_status;
  bit [7:0]    m_mask;
  bit          m_nmi_pend;
  bit          m_irq;
  bit [NSRC:0] seen [1:3];   // seen[k] = {src_nmi, src_irq} as sampled k edges ago
  bit          phi2_last;    // phi2 as sampled at the previous edge

  task automatic model_reset();
    m_status   = 8'h00;
    m_mask     = 8'h00;
    m_nmi_pend = 1'b0;
    m_irq      = 1'b1;
    for (int k = 1; k <= 3; k++) seen[k] = '0;
    phi2_last  = 1'b0;
  endtask

  // A source edge counts once it was high 2 edges ago and low 3 edges ago
  task automatic model_edge();
    bit [NSRC:0] edges;
    bit          bus;
    bit [15:0]   o;
    bit          any_pend;
    edges     = seen[2] & ~seen[3];
    seen[3]   = seen[2];
    seen[2]   = seen[1];
    seen[1]   = {src_nmi, src_irq};
    bus       = phi2 && !phi2_last;
    phi2_last = phi2;
    o         = addr - BASE;
    any_pend  = (m_status & m_mask) != 8'h00;
    if (bus && !rw && o == 16'd0) m_status = m_status & ~wdata;
    if (bus && !rw && o == 16'd1) m_mask = wdata & 8'h0F;
    m_status = m_status | 8'(edges[NSRC-1:0]);
    if (bus && rw && addr == 16'hFFFA) m_nmi_pend = 1'b0;
    if (edges[NSRC]) m_nmi_pend = 1'b1;
    m_irq = !any_pend;
  endtask

  function automatic logic [7:0] exp_rdata(input logic [15:0] a);
    logic [15:0] o;
    logic [7:0]  p;
    logic [7:0]  r;
    o = a - BASE;
    p = m_status & m_mask;
    r = 8'h00;
    if (o == 16'd0) r = m_status;
    if (o == 16'd1) r = m_mask;
    if (o == 16'd2) begin
      r = 8'h80;
      for (int i = NSRC - 1; i >= 0; i--) if (p[i]) r = 8'(i);
    end
    return r;
  endfunction

  // Advance one clock with current inputs and compare all outputs to the model
  task automatic step();
    logic [15:0] o;
    model_edge();
    @(posedge clk);
    #1;
    o = addr - BASE;
    check("irq", irq, m_irq);
    check("nmi", nmi, !m_nmi_pend);
    check("sel", sel, (o < 16'd3));
    check("rdata", rdata, exp_rdata(addr));
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic r);
    addr = a; wdata = d; rw = r; phi2 = 1'b0;
    step();
    phi2 = 1'b1;
    step();
    phi2 = 1'b0;
    step();
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr = a;
    rw   = 1'b1;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b0;
    src_irq = '0;
    src_nmi = 1'b0;
    addr    = 16'h0000;
    wdata   = 8'h00;
    rw      = 1'b1;
    phi2    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", irq, 1'b1);
    check("rst_nmi", nmi, 1'b1);
    rd_check("rst_status", BASE, 8'h00);
    rd_check("rst_mask", BASE + 16'd1, 8'h00);
    rd_check("rst_id", BASE + 16'd2, 8'h80);
    rd_check("outside", BASE + 16'd3, 8'h00);
    reset = 1'b1;

    // Single pulsed source, enabled
    bus_cycle(BASE + 16'd1, 8'h01, 1'b0);
    src_irq = 4'b0001;
    step(); step();
    src_irq = 4'b0000;
    step();
    rd_check("p033_status", BASE, 8'h01);
    step();
    check("p033_irq", irq, 1'b0);
    rd_check("p033_id", BASE + 16'd2, 8'h00);

    // Priority id and partial W1C
    bus_cycle(BASE, 8'hFF, 1'b0);
    bus_cycle(BASE + 16'd1, 8'h0F, 1'b0);
    src_irq = 4'b1010;
    steps(3);
    src_irq = 4'b0000;
    step();
    rd_check("p034_status", BASE, 8'h0A);
    rd_check("p034_id", BASE + 16'd2, 8'h01);
    bus_cycle(BASE, 8'h02, 1'b0);
    rd_check("p034_status2", BASE, 8'h08);
    rd_check("p034_id2", BASE + 16'd2, 8'h03);
    check("p034_irq", irq, 1'b0);

    // Edge coincident with W1C of the same bit
    bus_cycle(BASE, 8'hFF, 1'b0);
    addr = BASE; wdata = 8'h04; rw = 1'b0; phi2 = 1'b0;
    src_irq = 4'b0100;
    step(); step();
    phi2 = 1'b1;
    step();
    phi2 = 1'b0;
    src_irq = 4'b0000;
    step();
    rd_check("p035_status", BASE, 8'h04);

    // Masked source then enabling the mask
    bus_cycle(BASE + 16'd1, 8'h00, 1'b0);
    bus_cycle(BASE, 8'hFF, 1'b0);
    src_irq = 4'b1000;
    steps(3);
    src_irq = 4'b0000;
    steps(2);
    rd_check("p037_status", BASE, 8'h08);
    check("p037_irq_hi", irq, 1'b1);
    addr = BASE + 16'd1; wdata = 8'h08; rw = 1'b0; phi2 = 1'b0;
    step();
    phi2 = 1'b1;
    step();
    check("p037_irq_wr", irq, 1'b1);
    phi2 = 1'b0;
    step();
    check("p037_irq_lo", irq, 1'b0);

    // NMI latch and vector-read acknowledge
    src_nmi = 1'b1;
    steps(3);
    check("p036_nmi_lo", nmi, 1'b0);
    src_nmi = 1'b0;
    bus_cycle(16'hFFFE, 8'h00, 1'b1);
    check("p036_fffe", nmi, 1'b0);
    addr = 16'hFFFA; rw = 1'b1; phi2 = 1'b0;
    step();
    phi2 = 1'b1;
    step();
    check("p036_fffa", nmi, 1'b1);
    phi2 = 1'b0;
    step();

    // Asynchronous reset with pending work, and a source held across release
    bus_cycle(BASE, 8'hFF, 1'b0);
    src_irq = 4'b1111;
    src_nmi = 1'b1;
    steps(3);
    src_irq = 4'b0000;
    src_nmi = 1'b0;
    step();
    rd_check("p038_pre", BASE, 8'h0F);
    check("p038_pre_nmi", nmi, 1'b0);
    src_irq = 4'b0010;
    reset   = 1'b0;
    #1;
    model_reset();
    check("p038_irq", irq, 1'b1);
    check("p038_nmi", nmi, 1'b1);
    rd_check("p038_status", BASE, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    steps(3);
    rd_check("held_src", BASE, 8'h02);
    src_irq = 4'b0000;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NSRC; b++)
        if ($urandom_range(0, 7) == 0) src_irq[b] = ~src_irq[b];
      if ($urandom_range(0, 15) == 0) src_nmi = ~src_nmi;
      if ($urandom_range(0, 1) == 0) phi2 = ~phi2;
      if (!phi2) begin
        case ($urandom_range(0, 6))
          0: addr = BASE;
          1: addr = BASE + 16'd1;
          2: addr = BASE + 16'd2;
          3: addr = BASE + 16'd3;
          4: addr = 16'hFFFA;
          5: addr = 16'hFFFE;
          default: addr = 16'($urandom);
        endcase
        rw    = 1'($urandom_range(0, 1));
        wdata = 8'($urandom);
      end
      step();
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        #2;
        model_reset();
        check("rnd_rst_irq", irq, 1'b1);
        check("rnd_rst_nmi", nmi, 1'b1);
        check("rnd_rst_rdata", rdata, exp_rdata(addr));
        @(posedge clk);
        #1;
        reset = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
